seq_det_scheduler: RTL and testbench

Round-robin scheduler that shares one serial sequence-detector core (single X input, Mealy outputs D and B, active-low clear) among NREQ requesters. Each requester submits a WIDTH-bit word. The scheduler clears the detector, shifts the word in LSB-first, and counts D and B pulses. It returns both counts to the requester with a one-cycle ack. The detector instance sits outside this block and connects through the det_* ports.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/seq_det_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_seq_det_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared state encoding and default sizing for the sequence-detector scheduler.
package seq_det_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping modulo NREQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  // Scan NREQ positions starting at the pointer and keep the first hit
  always_comb begin
    logic [PW-1:0] j;
    logic          found;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = PW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
        valid_o  = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one external serial sequence detector among
// NREQ requesters. Optional feature macro: SEQ_SCHED_ABORT_EN (abort on req drop).
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  WIDTH = WIDTH_DEF,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [CW-1:0]         d_cnt,
  output logic [CW-1:0]         b_cnt,
  output logic                  det_x,
  output logic                  det_clr_n,
  input  logic                  det_d,
  input  logic                  det_b
);

  localparam int PW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     dacc_q, dacc_d;
  logic [CW-1:0]     bacc_q, bacc_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic              detx_q, detx_d;
  logic              clrn_q, clrn_d;

  logic [NREQ-1:0]   arb_gnt_s;
  logic [PW-1:0]     arb_idx_s;
  logic              arb_valid_s;
  logic              abort_s;
  logic              last_bit_s;
  logic [PW-1:0]     next_ptr_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (inc && (v != CW'(WIDTH))) begin
      return v + CW'(1);
    end else begin
      return v;
    end
  endfunction

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  assign last_bit_s = (bit_q == CW'(WIDTH - 1));
  assign next_ptr_s = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

  // The granted requester withdrawing mid-job cancels the job
`ifdef SEQ_SCHED_ABORT_EN
  assign abort_s = ((state_q == CLEAR) || (state_q == SHIFT)) && !req[idx_q];
`else
  assign abort_s = 1'b0;
`endif

  // Next-state, datapath and output-register next values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    dacc_d  = dacc_q;
    bacc_d  = bacc_q;
    grant_d = grant_q;
    ack_d   = '0;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    if (abort_s) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = next_ptr_s;
    end else begin
      case (state_q)
        IDLE: begin
          grant_d = '0;
          if (arb_valid_s) begin
            state_d = CLEAR;
            idx_d   = arb_idx_s;
            grant_d = arb_gnt_s;
            shreg_d = req_data[int'(arb_idx_s)*WIDTH +: WIDTH];
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          bit_d   = '0;
          dacc_d  = '0;
          bacc_d  = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + CW'(1);
          dacc_d  = sat_inc(dacc_q, det_d);
          bacc_d  = sat_inc(bacc_q, det_b);
          if (last_bit_s) begin
            // Publish counts together with the ack in DONE
            state_d = DONE;
            ack_d   = grant_q;
            dcnt_d  = sat_inc(dacc_q, det_d);
            bcnt_d  = sat_inc(bacc_q, det_b);
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = next_ptr_s;
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    clrn_d = (state_d == SHIFT) || (state_d == DONE);
    detx_d = (state_d == SHIFT) ? shreg_d[0] : 1'b0;
  end

  // State, datapath and registered outputs
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      dacc_q  <= '0;
      bacc_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      detx_q  <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      dacc_q  <= dacc_d;
      bacc_q  <= bacc_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      detx_q  <= detx_d;
      clrn_q  <= clrn_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign d_cnt     = dcnt_q;
  assign b_cnt     = bcnt_q;
  assign det_x     = detx_q;
  assign det_clr_n = clrn_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed and random jobs against a word-level model.
// Define SEQ_SCHED_ABORT_EN for both bench and RTL to cover the abort path.
module tb_seq_det_scheduler;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic                  CLK = 1'b0;
  logic                  CLR = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       grant, ack;
  logic                  busy, det_x, det_clr_n, det_d, det_b;
  logic [CW-1:0]         d_cnt, b_cnt;
  logic                  b_en = 1'b0;
  logic [1:0]            hist;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_d    = 0;
  int m_b    = 0;

  always #5 CLK = ~CLK;

  seq_det_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .ack       (ack),
    .busy      (busy),
    .d_cnt     (d_cnt),
    .b_cnt     (b_cnt),
    .det_x     (det_x),
    .det_clr_n (det_clr_n),
    .det_d     (det_d),
    .det_b     (det_b)
  );

  // Detector stand-in: D echoes X, B marks a 1,0,0 run ending on the current bit
  assign det_d = det_x & det_clr_n;
  assign det_b = b_en & det_clr_n & ~det_x & ~hist[0] & hist[1];
  always @(posedge CLK) begin
    if (!det_clr_n) hist <= 2'b00;
    else            hist <= {hist[0], det_x};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] t;
    for (int i = 0; i < NREQ; i++) begin
      t = r >> ((p + i) % NREQ);
      if (t[0]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic int count_100(input logic [WIDTH-1:0] w);
    int n;
    logic [2:0] win;
    n = 0;
    for (int i = 2; i < WIDTH; i++) begin
      win = 3'(w >> (i - 2));
      if (win == 3'b001) n++;
    end
    return n;
  endfunction

  // Called in an IDLE cycle with a nonzero req already applied
  task automatic do_job(input logic drop);
    int w, ed, eb;
    logic [WIDTH-1:0] word, sh;
    logic [NREQ-1:0]  oh;
    w    = pick(req, m_ptr);
    word = WIDTH'(req_data >> (w * WIDTH));
    oh   = NREQ'(1) << w;
    ed   = $countones(word);
    eb   = b_en ? count_100(word) : 0;
    @(negedge CLK);
    check("clear_grant", grant, oh);
    check("clear_busy", busy, 1);
    check("clear_detclr", det_clr_n, 0);
    check("clear_ack", ack, 0);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge CLK);
      sh = word >> k;
      check("shift_x", det_x, sh[0]);
      check("shift_detclr", det_clr_n, 1);
      check("shift_grant", grant, oh);
    end
    @(negedge CLK);
    check("done_ack", ack, oh);
    check("done_grant", grant, oh);
    check("done_d", d_cnt, ed);
    check("done_b", b_cnt, eb);
    m_ptr = (w + 1) % NREQ;
    m_d   = ed;
    m_b   = eb;
    if (drop) req = req & ~oh;
    @(negedge CLK);
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    check("idle_ack", ack, 0);
    check("idle_detclr", det_clr_n, 0);
    check("idle_d_hold", d_cnt, m_d);
    check("idle_b_hold", b_cnt, m_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_d", d_cnt, 0);
    check("rst_b", b_cnt, 0);
    check("rst_x", det_x, 0);
    check("rst_detclr", det_clr_n, 0);
    CLR = 1'b1;
    @(negedge CLK);

    // Word 0xA5 on requester 0, B disabled
    req_data = {8'h00, 8'hA5};
    req      = 2'b01;
    do_job(1'b1);

    // Reset mid-job in the third SHIFT cycle
    req = 2'b01;
    repeat (4) @(negedge CLK);
    check("pre_clr_busy", busy, 1);
    CLR = 1'b0;
    req = '0;
    #1;
    check("clr_grant", grant, 0);
    check("clr_ack", ack, 0);
    check("clr_busy", busy, 0);
    check("clr_d", d_cnt, 0);
    check("clr_x", det_x, 0);
    check("clr_detclr", det_clr_n, 0);
    @(negedge CLK);
    CLR   = 1'b1;
    m_ptr = 0;
    m_d   = 0;
    m_b   = 0;
    repeat (2) @(negedge CLK);
    check("post_clr_ack", ack, 0);

    // Both requesters held: alternation from pointer 0
    req_data = {8'h00, 8'hFF};
    req      = 2'b11;
    do_job(1'b0);
    do_job(1'b0);
    do_job(1'b1);
    req = '0;

    // B detection on 0x11
    b_en     = 1'b1;
    req_data = {8'h00, 8'h11};
    req      = 2'b01;
    do_job(1'b1);

    // Random jobs
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        repeat (2) @(negedge CLK);
        check("gap_busy", busy, 0);
        check("gap_d_hold", d_cnt, m_d);
      end
      b_en     = 1'($urandom_range(0, 1));
      req_data = (NREQ*WIDTH)'($urandom);
      req      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_job(1'b1);
    end

`ifdef SEQ_SCHED_ABORT_EN
    // Granted requester withdraws in SHIFT cycle 4; the other waits
    begin
      int w;
      logic [NREQ-1:0] oh;
      b_en     = 1'b0;
      req_data = (NREQ*WIDTH)'($urandom);
      req      = 2'b11;
      w        = pick(req, m_ptr);
      oh       = NREQ'(1) << w;
      @(negedge CLK);
      check("ab_grant", grant, oh);
      repeat (4) @(negedge CLK);
      req = req & ~oh;
      @(negedge CLK);
      check("ab_busy", busy, 0);
      check("ab_grant_drop", grant, 0);
      check("ab_ack", ack, 0);
      check("ab_detclr", det_clr_n, 0);
      check("ab_d_hold", d_cnt, m_d);
      m_ptr = (w + 1) % NREQ;
      do_job(1'b1);
    end
`endif

    req = '0;
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
